// File: rtl/gf_pkg.sv
// Shared definitions for the time-multiplexed glitch filter: one-hot state codes
// and the state-to-level mapping used by the engine and the scheduler.
package gf_pkg;

    localparam int GF_SW = 4;

    typedef enum logic [GF_SW-1:0] {
        S_LO   = 4'b0001,
        S_RISE = 4'b0010,
        S_HI   = 4'b0100,
        S_FALL = 4'b1000
    } gf_state_e;

    // Any code other than S_HI/S_FALL, including corrupted ones, reads as low.
    function automatic logic gf_level(input logic [GF_SW-1:0] st);
        return (st == S_HI) || (st == S_FALL);
    endfunction

endpackage

// File: rtl/glitch_filter_step.sv
// Combinational next-state engine for one glitch-filter channel; the scheduler
// owns the per-channel state registers and shares this single instance.
//
//   state  | meaning
//   S_LO   | stable low
//   S_RISE | one high sample seen while low
//   S_HI   | stable high
//   S_FALL | one low sample seen while high
module glitch_filter_step
    import gf_pkg::*;
(
    input  logic [GF_SW-1:0] cur_state,
    input  logic             sample,
    output logic [GF_SW-1:0] nxt_state,
    output logic             level
);

    always_comb begin
        nxt_state = S_LO;
        case (cur_state)
            S_LO:    nxt_state = sample ? S_RISE : S_LO;
            S_RISE:  nxt_state = sample ? S_HI   : S_LO;
            S_HI:    nxt_state = sample ? S_HI   : S_FALL;
            S_FALL:  nxt_state = sample ? S_HI   : S_LO;
            default: nxt_state = S_LO;
        endcase
    end

    assign level = gf_level(nxt_state);

endmodule

// File: rtl/glitch_filter_scheduler.sv
// Round-robin scheduler sharing one glitch_filter_step across NCH inputs, with a
// single-entry valid/ready event port. Define GF_SYNC_EN to add 2-flop input synchronisers.
module glitch_filter_scheduler
    import gf_pkg::*;
#(
    parameter  int NCH      = 8,
    parameter  int PRESCALE = 16,
    localparam int CW       = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] in,
    output logic [NCH-1:0] filt_out,
    output logic           ev_valid,
    input  logic           ev_ready,
    output logic [CW-1:0]  ev_ch,
    output logic           ev_level,
    output logic           ev_overflow,
    input  logic           ovf_clr
);

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0]  PTR_LAST = CW'(NCH - 1);

    logic [PW-1:0]    pre_cnt;
    logic [CW-1:0]    ptr;
    logic             tick;
    logic [NCH-1:0]   samp;
    logic [GF_SW-1:0] st_mem [NCH];
    logic [GF_SW-1:0] cur_state;
    logic [GF_SW-1:0] nxt_state;
    logic             new_lvl;
    logic             ev_new;
    logic             ev_accept;

`ifdef GF_SYNC_EN
    logic [NCH-1:0] sync_q1;
    logic [NCH-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in;
            sync_q2 <= sync_q1;
        end
    end

    assign samp = sync_q2;
`else
    assign samp = in;
`endif

    assign tick = en && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (tick) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    assign cur_state = st_mem[ptr];

    glitch_filter_step u_step (
        .cur_state (cur_state),
        .sample    (samp[ptr]),
        .nxt_state (nxt_state),
        .level     (new_lvl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                st_mem[i] <= S_LO;
            end
            filt_out <= '0;
        end else if (tick) begin
            st_mem[ptr]   <= nxt_state;
            filt_out[ptr] <= new_lvl;
        end
    end

    // A held event that is not leaving this cycle blocks the new one; the filter still advances.
    assign ev_new    = tick && (new_lvl != filt_out[ptr]);
    assign ev_accept = ev_valid && ev_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid    <= 1'b0;
            ev_ch       <= '0;
            ev_level    <= 1'b0;
            ev_overflow <= 1'b0;
        end else begin
            if (ev_new && (!ev_valid || ev_ready)) begin
                ev_valid <= 1'b1;
                ev_ch    <= ptr;
                ev_level <= new_lvl;
            end else if (ev_accept) begin
                ev_valid <= 1'b0;
            end

            if (ev_new && ev_valid && !ev_ready) begin
                ev_overflow <= 1'b1;
            end else if (ovf_clr) begin
                ev_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_glitch_filter_scheduler.sv
// Directed bench for glitch_filter_scheduler at NCH=4, PRESCALE=4; channel p is
// visited at edge 4+4p+16k after reset release while en stays high.
module tb_glitch_filter_scheduler;

    localparam int NCH      = 4;
    localparam int PRESCALE = 4;
    localparam int CW       = $clog2(NCH);

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] in;
    logic [NCH-1:0] filt_out;
    logic           ev_valid;
    logic           ev_ready;
    logic [CW-1:0]  ev_ch;
    logic           ev_level;
    logic           ev_overflow;
    logic           ovf_clr;

    int             n_checks = 0;
    int             n_err    = 0;
    int             cyc      = 0;
    int             ev_cnt   = 0;
    int             base     = 0;
    logic [CW-1:0]  last_ch  = '0;
    logic           exp_f3;

    glitch_filter_scheduler #(
        .NCH      (NCH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in          (in),
        .filt_out    (filt_out),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_level    (ev_level),
        .ev_overflow (ev_overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            ev_cnt  <= ev_cnt + 1;
            last_ch <= ev_ch;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to edge e (counted from reset release) and settle 1 time unit past it.
    task automatic go(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_filt",  32'(filt_out),    32'h0);
        chk("rst_valid", 32'(ev_valid),    32'h0);
        chk("rst_ovf",   32'(ev_overflow), 32'h0);

        // steady high on ch2, consumer always ready
        rst = 1'b0; cyc = 0;
        in = 4'b0100; ev_ready = 1'b1;
        go(12);  chk("ch2_first_visit", 32'(filt_out), 32'h0);
        go(27);  chk("ch2_pre_filt", 32'(filt_out), 32'h0);
                 chk("ch2_pre_valid", 32'(ev_valid), 32'h0);
        go(28);  chk("ch2_filt", 32'(filt_out), 32'h4);
                 chk("ch2_valid", 32'(ev_valid), 32'h1);
                 chk("ch2_ev_ch", 32'(ev_ch), 32'h2);
                 chk("ch2_ev_lvl", 32'(ev_level), 32'h1);
        go(29);  chk("ch2_drained", 32'(ev_valid), 32'h0);
                 chk("ch2_evcnt", 32'(ev_cnt), 32'h1);
        in = 4'b1100;

        // single-sample glitch on ch1 (sampled only at edge 40)
        go(36);  in = 4'b1110;
        go(41);  ev_ready = 1'b0;
                 chk("ch3_rise_only", 32'(filt_out), 32'h4);
        go(44);  in = 4'b1100;
        go(48);  chk("ch3_filt", 32'(filt_out), 32'hC);
                 chk("ch3_valid", 32'(ev_valid), 32'h1);
                 chk("ch3_ev_ch", 32'(ev_ch), 32'h3);
        go(57);  chk("glitch_rejected", 32'(filt_out), 32'hC);
                 chk("held_ev_ch", 32'(ev_ch), 32'h3);
                 chk("held_ev_lvl", 32'(ev_level), 32'h1);
                 chk("glitch_no_ev", 32'(ev_cnt), 32'h1);

        // reset in the middle of a scan with an event pending
        go(58);  rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_filt",  32'(filt_out), 32'h0);
        chk("mid_rst_valid", 32'(ev_valid), 32'h0);
        chk("mid_rst_ev_ch", 32'(ev_ch),    32'h0);
        chk("mid_rst_lvl",   32'(ev_level), 32'h0);

        // ch0 and ch3 rise together, consumer stalled: ch3 event dropped
        rst = 1'b0; cyc = 0;
        in = 4'b1001; ev_ready = 1'b0;
        go(19);  chk("ptr_restart_pre", 32'(ev_valid), 32'h0);
        go(20);  chk("ch0_valid", 32'(ev_valid), 32'h1);
                 chk("ch0_ev_ch", 32'(ev_ch), 32'h0);
                 chk("ch0_filt", 32'(filt_out), 32'h1);
        go(31);  chk("ovf_pre", 32'(ev_overflow), 32'h0);
        go(32);  chk("drop_filt", 32'(filt_out), 32'h9);
                 chk("drop_ovf", 32'(ev_overflow), 32'h1);
                 chk("drop_held_ch", 32'(ev_ch), 32'h0);
        go(33);  ovf_clr = 1'b1; in = 4'b0001;
        go(34);  ovf_clr = 1'b0;
                 chk("ovf_cleared", 32'(ev_overflow), 32'h0);
                 chk("ovf_clr_valid", 32'(ev_valid), 32'h1);

        // ch3 falls at edge 64 while stalled and ovf_clr is high: set wins
        go(63);  ovf_clr = 1'b1;
        go(64);  ovf_clr = 1'b0;
                 chk("set_wins_ovf", 32'(ev_overflow), 32'h1);
                 chk("set_wins_filt", 32'(filt_out), 32'h1);
                 chk("set_wins_ch", 32'(ev_ch), 32'h0);
        go(65);  in = 4'b0011;
        go(70);  ovf_clr = 1'b1;
        go(71);  ovf_clr = 1'b0;
                 chk("ovf_clr2", 32'(ev_overflow), 32'h0);

        // accept held ch0 event in the same cycle ch1 raises a new one
        go(87);  ev_ready = 1'b1; base = ev_cnt;
                 chk("pre_accept_ch", 32'(ev_ch), 32'h0);
        go(88);  chk("acc_cnt1", 32'(ev_cnt - base), 32'h1);
                 chk("acc_first_ch", 32'(last_ch), 32'h0);
                 chk("acc_valid", 32'(ev_valid), 32'h1);
                 chk("acc_new_ch", 32'(ev_ch), 32'h1);
                 chk("acc_new_lvl", 32'(ev_level), 32'h1);
                 chk("acc_no_ovf", 32'(ev_overflow), 32'h0);
                 chk("acc_filt", 32'(filt_out), 32'h3);
        go(89);  chk("acc_cnt2", 32'(ev_cnt - base), 32'h2);
                 chk("acc_second_ch", 32'(last_ch), 32'h1);
                 chk("acc_drained", 32'(ev_valid), 32'h0);

        // freeze for 20 cycles with inputs toggling
        go(90);  en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            go(91 + i);
            in = ~in;
        end
        in = 4'b0111;
        go(110); chk("frz_filt", 32'(filt_out), 32'h3);
                 chk("frz_valid", 32'(ev_valid), 32'h0);
                 chk("frz_evcnt", 32'(ev_cnt), 32'h3);
        en = 1'b1;
        go(127); chk("unfrz_pre", 32'(filt_out), 32'h3);
        go(128); chk("unfrz_filt", 32'(filt_out), 32'h7);
                 chk("unfrz_ev_ch", 32'(ev_ch), 32'h2);
                 chk("unfrz_valid", 32'(ev_valid), 32'h1);

        // ch3 goes high one cycle before its visit at edge 132
        go(131); in = 4'b1111;
`ifdef GF_SYNC_EN
        exp_f3 = 1'b0;
`else
        exp_f3 = 1'b1;
`endif
        go(147); chk("lat_pre", 32'(filt_out), 32'h7);
        go(148); chk("lat_ch3", 32'(filt_out[3]), 32'(exp_f3));
        go(164); chk("lat_final", 32'(filt_out), 32'hF);
        go(170); chk("total_events", 32'(ev_cnt), 32'h5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
